// File: rtl/bram1_be_server.sv
// Credit-based request/response front end for a single-port byte-enable BRAM.
// Define BRAM_WRITE_RESP_EN to make writes return the merged word as a response.
module bram1_be_server #(
    parameter int unsigned ADDR_WIDTH = 1,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned WE_WIDTH   = 1,
    parameter int unsigned PIPELINED  = 0,
    parameter int unsigned RESP_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic [WE_WIDTH-1:0]   REQ_WE,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ_DATA,
    output logic                  RESP_VALID,
    input  logic                  RESP_READY,
    output logic [DATA_WIDTH-1:0] RESP_DATA,
    output logic                  BRAM_EN,
    output logic [WE_WIDTH-1:0]   BRAM_WE,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
    output logic [DATA_WIDTH-1:0] BRAM_DI,
    input  logic [DATA_WIDTH-1:0] BRAM_DO
);

    localparam int unsigned LAT = (PIPELINED != 0) ? 2 : 1;
    localparam int unsigned PW  = $clog2(RESP_DEPTH);
    localparam int unsigned CW  = $clog2(RESP_DEPTH) + 1;

    logic [LAT-1:0]        tag_sr;
    logic [DATA_WIDTH-1:0] fifo_mem [RESP_DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         credit;
    logic [CW-1:0]         credit_nxt;
    logic                  ready_q;
    logic                  accept;
    logic                  tag_in;
    logic                  push;
    logic                  pop;

    // BRAM port is driven straight from the request when it is accepted.
    assign accept    = REQ_VALID & ready_q;
    assign BRAM_EN   = accept;
    assign BRAM_WE   = accept ? REQ_WE : '0;
    assign BRAM_ADDR = REQ_ADDR;
    assign BRAM_DI   = REQ_DATA;

`ifdef BRAM_WRITE_RESP_EN
    assign tag_in = accept;
`else
    assign tag_in = accept & (REQ_WE == '0);
`endif

    assign push       = tag_sr[LAT-1];
    assign RESP_VALID = (count != '0);
    assign pop        = RESP_VALID & RESP_READY;
    assign RESP_DATA  = fifo_mem[rptr];
    assign REQ_READY  = ready_q;

    // Credits cover queued responses plus tags still travelling through the BRAM.
    assign credit_nxt = credit + CW'(tag_in) - CW'(pop);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tag_sr  <= '0;
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            credit  <= '0;
            ready_q <= 1'b0;
        end else begin
            tag_sr  <= LAT'({tag_sr, tag_in});
            credit  <= credit_nxt;
            ready_q <= (credit_nxt < CW'(RESP_DEPTH));
            count   <= count + CW'(push) - CW'(pop);
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
        end
    end

    // Response storage needs no reset; validity is tracked by count.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wptr] <= BRAM_DO;
        end
    end

endmodule

// File: tb/tb_bram1_be_server.sv
// Scoreboard bench for bram1_be_server: one instance per BRAM latency, each with its own BRAM model.
module tb_bram1_be_server;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 16;
    localparam int unsigned WW    = 2;
    localparam int unsigned DEPTH = 4;
`ifdef BRAM_WRITE_RESP_EN
    localparam bit WR_RESP = 1'b1;
`else
    localparam bit WR_RESP = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid  [2];
    logic          req_ready  [2];
    logic [WW-1:0] req_we     [2];
    logic [AW-1:0] req_addr   [2];
    logic [DW-1:0] req_data   [2];
    logic          resp_valid [2];
    logic          resp_ready [2];
    logic [DW-1:0] resp_data  [2];
    logic          bram_en    [2];
    logic [WW-1:0] bram_we    [2];
    logic [AW-1:0] bram_addr  [2];
    logic [DW-1:0] bram_di    [2];
    logic [DW-1:0] bram_do    [2];

    logic [DW-1:0] ref_mem [2][256];
    logic [DW-1:0] exp_q   [2][$];
    int            ts_q    [2][$];
    int            cyc     = 0;
    bit            lat_chk = 1'b0;
    int            n_cmp   = 0;
    int            n_err   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_word(input int a);
        logic [7:0] b;
        b = 8'(a);
        if (a == 3)   return 16'h00A5;
        if (a == 255) return 16'h0000;
        return {b ^ 8'h3C, b};
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] di,
                                            input logic [WW-1:0] we);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < int'(WW); b++)
            if (we[b]) r[8*b +: 8] = di[8*b +: 8];
        return r;
    endfunction

    generate
        for (genvar g = 0; g < 2; g++) begin : gen_dut
            logic [DW-1:0] bmem [256];
            logic [DW-1:0] do1;
            logic [DW-1:0] do2;

            bram1_be_server #(
                .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW),
                .PIPELINED(g), .RESP_DEPTH(DEPTH)
            ) u_dut (
                .CLK(clk), .RST_N(rst_n),
                .REQ_VALID(req_valid[g]), .REQ_READY(req_ready[g]),
                .REQ_WE(req_we[g]), .REQ_ADDR(req_addr[g]), .REQ_DATA(req_data[g]),
                .RESP_VALID(resp_valid[g]), .RESP_READY(resp_ready[g]), .RESP_DATA(resp_data[g]),
                .BRAM_EN(bram_en[g]), .BRAM_WE(bram_we[g]), .BRAM_ADDR(bram_addr[g]),
                .BRAM_DI(bram_di[g]), .BRAM_DO(bram_do[g])
            );

            initial for (int a = 0; a < 256; a++) bmem[a] = init_word(a);

            // Write-first BRAM; second output register when pipelined.
            always @(posedge clk) begin
                if (bram_en[g]) begin
                    bmem[bram_addr[g]] <= merge(bmem[bram_addr[g]], bram_di[g], bram_we[g]);
                    do1 <= merge(bmem[bram_addr[g]], bram_di[g], bram_we[g]);
                end
                do2 <= do1;
            end
            assign bram_do[g] = (g == 1) ? do2 : do1;
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                exp_q[d].delete();
                ts_q[d].delete();
            end else begin
                if (resp_valid[d] && resp_ready[d]) begin
                    if (exp_q[d].size() == 0) begin
                        chk($sformatf("d%0d stale_resp", d), 32'd1, 32'd0);
                    end else begin
                        chk($sformatf("d%0d resp_data", d), 32'(resp_data[d]), 32'(exp_q[d].pop_front()));
                        if (lat_chk) chk($sformatf("d%0d resp_lat", d), 32'(cyc - ts_q[d][0]), 32'(d + 2));
                        void'(ts_q[d].pop_front());
                    end
                end
                if (req_valid[d] && req_ready[d]) begin
                    if (req_we[d] == '0) begin
                        exp_q[d].push_back(ref_mem[d][req_addr[d]]);
                        ts_q[d].push_back(cyc);
                    end else begin
                        ref_mem[d][req_addr[d]] = merge(ref_mem[d][req_addr[d]], req_data[d], req_we[d]);
`ifdef BRAM_WRITE_RESP_EN
                        exp_q[d].push_back(ref_mem[d][req_addr[d]]);
                        ts_q[d].push_back(cyc);
`endif
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int d, input int ncyc, input int base, output int acc);
        acc = 0;
        req_we[d]    = '0;
        req_addr[d]  = AW'(base);
        req_valid[d] = 1'b1;
        repeat (ncyc) begin
            @(negedge clk);
            if (req_ready[d]) acc++;
            @(posedge clk);
            #1;
            req_addr[d] = AW'(base + acc);
        end
        req_valid[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        resp_ready[d] = 1'b1;
        for (int i = 0; i < 50 && exp_q[d].size() != 0; i++) tick();
        chk($sformatf("d%0d drain_left", d), 32'(exp_q[d].size()), 32'd0);
        tick();
        tick();
        chk($sformatf("d%0d drain_valid", d), 32'(resp_valid[d]), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc;
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 256; a++) ref_mem[d][a] = init_word(a);
            req_valid[d]  = 1'b1;
            req_we[d]     = 2'b11;
            req_addr[d]   = '0;
            req_data[d]   = '0;
            resp_ready[d] = 1'b0;
        end

        // Reset: outputs held low even with a request pending.
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d rst_req_ready", d), 32'(req_ready[d]), 32'd0);
            chk($sformatf("d%0d rst_resp_valid", d), 32'(resp_valid[d]), 32'd0);
            chk($sformatf("d%0d rst_bram_en", d), 32'(bram_en[d]), 32'd0);
            chk($sformatf("d%0d rst_bram_we", d), 32'(bram_we[d]), 32'd0);
            req_valid[d] = 1'b0;
            req_we[d]    = '0;
        end
        rst_n = 1'b1;
        #1;
        chk("d0 rel_ready_before_edge", 32'(req_ready[0]), 32'd0);
        tick();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d rel_ready", d), 32'(req_ready[d]), 32'd1);
            chk($sformatf("d%0d rel_resp_valid", d), 32'(resp_valid[d]), 32'd0);
        end

        // Single read of address 3, latency 1.
        lat_chk       = 1'b1;
        resp_ready[0] = 1'b1;
        req_addr[0]   = 8'd3;
        req_valid[0]  = 1'b1;
        tick();
        req_valid[0] = 1'b0;
        chk("d0 rd_valid_at_accept", 32'(resp_valid[0]), 32'd0);
        tick();
        chk("d0 rd_valid_next", 32'(resp_valid[0]), 32'd1);
        chk("d0 rd_data_a5", 32'(resp_data[0]), 32'h00A5);
        drain(0);

        // Pipelined back-to-back reads at full rate.
        resp_ready[1] = 1'b1;
        stream(1, 8, 0, acc);
        chk("d1 b2b_accepts", 32'(acc), 32'd8);
        drain(1);
        lat_chk = 1'b0;

        // Backpressure: credits stop acceptance at RESP_DEPTH.
        for (int d = 0; d < 2; d++) begin
            resp_ready[d] = 1'b0;
            stream(d, 10, 16, acc);
            chk($sformatf("d%0d bp_accepts", d), 32'(acc), 32'(DEPTH));
            chk($sformatf("d%0d bp_ready", d), 32'(req_ready[d]), 32'd0);
            chk($sformatf("d%0d bp_valid", d), 32'(resp_valid[d]), 32'd1);
            drain(d);
        end

        // Byte-enable write, then read back the merged word.
        resp_ready[0] = 1'b0;
        req_we[0]     = 2'b01;
        req_data[0]   = 16'h1234;
        req_addr[0]   = 8'hFF;
        req_valid[0]  = 1'b1;
        tick();
        req_valid[0] = 1'b0;
        req_we[0]    = '0;
        repeat (3) tick();
        chk("d0 wr_resp_valid", 32'(resp_valid[0]), 32'(WR_RESP));
        chk("d0 wr_resp_data", resp_valid[0] ? 32'(resp_data[0]) : 32'd0, WR_RESP ? 32'h0034 : 32'd0);
        drain(0);
        resp_ready[0] = 1'b0;
        req_addr[0]   = 8'hFF;
        req_valid[0]  = 1'b1;
        tick();
        req_valid[0] = 1'b0;
        tick();
        chk("d0 wr_readback", 32'(resp_data[0]), 32'h0034);
        drain(0);

        // Reset with two queued responses and two tags in flight.
        resp_ready[1] = 1'b0;
        stream(1, 4, 32, acc);
        chk("d1 pre_rst_accepts", 32'(acc), 32'd4);
        chk("d1 pre_rst_valid", 32'(resp_valid[1]), 32'd1);
        rst_n = 1'b0;
        #3;
        chk("d1 mid_rst_valid", 32'(resp_valid[1]), 32'd0);
        chk("d1 mid_rst_ready", 32'(req_ready[1]), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        resp_ready[1] = 1'b1;
        repeat (6) tick();
        chk("d1 post_rst_valid", 32'(resp_valid[1]), 32'd0);
        chk("d1 post_rst_ready", 32'(req_ready[1]), 32'd1);
        stream(1, 2, 5, acc);
        chk("d1 post_rst_accepts", 32'(acc), 32'd2);
        drain(1);

        for (int d = 0; d < 2; d++)
            chk($sformatf("d%0d final_empty", d), 32'(exp_q[d].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
